// File: rtl/shared_mem_arbiter_pkg.sv
// shared_mem_arbiter_pkg: state encoding and default widths for the shared memory front end
package shared_mem_arbiter_pkg;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int STARVE_MAX_DEF = 3;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IACC = 2'd1,
    ARB_DACC = 2'd2
  } arb_state_e;
endpackage

// File: rtl/shared_mem_arbiter_starve.sv
// shared_mem_arbiter_starve: saturating count of data grants made while an ifetch is waiting
module shared_mem_arbiter_starve #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);
  localparam int CW = $clog2(MAX + 2);
  logic [CW-1:0] cnt_q;
  assign sat_o = cnt_q == CW'(MAX);
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (inc_i && !sat_o) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: arbitrates ifetch vs load/store onto a single-ported memory via req/ack
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] iaddr,
  input  logic          ireq,
  input  logic [AW-1:0] daddr,
  input  logic          read,
  input  logic          write,
  input  logic [DW-1:0] data_in,
  input  logic          flush,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] data_out,
  output logic          ready,
  output logic          instruction_ready,
  output logic          data_ready
);
  arb_state_e state_q;
  logic drop_q, idle, dreq, starved, igrant, dgrant;
  assign idle = state_q == ARB_IDLE;
  assign dreq = read | write;
  assign igrant = idle & ireq & (~dreq | starved);
  assign dgrant = idle & dreq & ~(ireq & starved);
  assign ready = idle;
  shared_mem_arbiter_starve #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~ireq | igrant),
    .inc_i (dgrant & ireq),
    .sat_o (starved)
  );
  // A dropped ifetch still completes the handshake and updates data_out, only its strobe is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ARB_IDLE;
      drop_q            <= 1'b0;
      mem_req           <= 1'b0;
      mem_wen           <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      data_out          <= '0;
      instruction_ready <= 1'b0;
      data_ready        <= 1'b0;
    end else begin
      instruction_ready <= 1'b0;
      data_ready        <= 1'b0;
      if (igrant || dgrant) begin
        state_q   <= igrant ? ARB_IACC : ARB_DACC;
        mem_req   <= 1'b1;
        mem_wen   <= dgrant & write;
        mem_addr  <= igrant ? iaddr : daddr;
        mem_wdata <= data_in;
      end else if (!idle && mem_ack) begin
        state_q           <= ARB_IDLE;
        mem_req           <= 1'b0;
        mem_wen           <= 1'b0;
        drop_q            <= 1'b0;
        data_out          <= mem_wen ? data_out : mem_rdata;
        instruction_ready <= state_q == ARB_IACC && !(drop_q || flush);
        data_ready        <= state_q == ARB_DACC;
      end else if (state_q == ARB_IACC && flush) begin
        drop_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_shared_mem_arbiter;
  localparam int SMAX = 3;
  logic clk = 1'b0, rst;
  logic [15:0] iaddr, daddr, data_in, mem_addr, mem_wdata, mem_rdata, data_out;
  logic ireq, read, write, flush, mem_req, mem_wen, mem_ack, ready, instruction_ready, data_ready;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.AW(16), .DW(16), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .ireq(ireq), .daddr(daddr), .read(read),
    .write(write), .data_in(data_in), .flush(flush), .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .data_out(data_out), .ready(ready), .instruction_ready(instruction_ready),
    .data_ready(data_ready)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk1(input string n, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", n, $time, got, exp);
    end
  endtask

  task automatic chk16(input string n, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", n, $time, got, exp);
    end
  endtask

  task automatic chk_s(input string n, input string got, input string exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", n, got, exp);
    end
  endtask

  // Transaction-level reference: one outstanding access, chosen by the arbitration rules
  bit m_busy = 0, m_drop = 0, m_is_i = 0, m_w = 0, m_ir = 0, m_dr = 0;
  logic [15:0] m_a = '0, m_wd = '0, m_dout = '0;
  int m_streak = 0;

  always @(posedge clk) begin
    m_ir = 0;
    m_dr = 0;
    if (rst) begin
      m_busy = 0; m_drop = 0; m_streak = 0; m_dout = '0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0;
        if (!m_w) m_dout = mem_rdata;
        m_ir = m_is_i && !(m_drop || flush);
        m_dr = !m_is_i;
        m_drop = 0;
      end else if (m_is_i && flush) m_drop = 1;
      if (!ireq) m_streak = 0;
    end else if (ireq || read || write) begin
      m_busy = 1;
      m_is_i = ireq && (!(read || write) || m_streak >= SMAX);
      m_a = m_is_i ? iaddr : daddr;
      m_w = !m_is_i && write;
      m_wd = data_in;
      m_streak = (m_is_i || !ireq) ? 0 : m_streak + 1;
    end else m_streak = 0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("mem_req", mem_req, m_busy);
      chk1("ready", ready, !m_busy);
      chk1("instruction_ready", instruction_ready, m_ir);
      chk1("data_ready", data_ready, m_dr);
      chk16("data_out", data_out, m_dout);
      if (m_busy) begin
        chk16("mem_addr", mem_addr, m_a);
        chk1("mem_wen", mem_wen, m_w);
        if (m_w) chk16("mem_wdata", mem_wdata, m_wd);
      end
    end
  end

  // Backend: acks after a (possibly random) delay while auto_ack is set
  bit auto_ack = 1, rand_dly = 0, rand_rd = 0;
  logic [15:0] rd_fix = '0;
  int b_cnt = 0, b_dly = 0;

  always @(posedge clk) begin
    #1;
    if (auto_ack) begin
      if (mem_ack) begin
        mem_ack = 0;
        b_cnt = 0;
      end else if (mem_req) begin
        if (b_cnt >= b_dly) begin
          mem_ack = 1;
          mem_rdata = rand_rd ? 16'($urandom) : rd_fix;
        end else b_cnt++;
      end else begin
        b_cnt = 0;
        b_dly = rand_dly ? int'($urandom_range(0, 4)) : 0;
      end
    end
  end

  string grants = "", irl = "";
  bit log_en = 0, prev_req = 0, ok, stable;
  logic [15:0] cap_addr, cap_wdata;
  logic cap_wen;

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_req && !prev_req) begin
      cap_addr = mem_addr;
      cap_wen = mem_wen;
      cap_wdata = mem_wdata;
      if (log_en) grants = (mem_addr == iaddr) ? {grants, "I"} : {grants, "D"};
    end
    prev_req = mem_req;
  endtask

  task automatic wait_strobe(input string n, input int maxc);
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      ok = instruction_ready || data_ready;
    end
    chk1(n, ok, 1'b1);
  endtask

  task automatic wait_req(input string n, input int maxc);
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      ok = mem_req;
    end
    chk1(n, ok, 1'b1);
  endtask

  initial begin
    int r;
    rst = 1; ireq = 0; read = 0; write = 0; flush = 0;
    iaddr = '0; daddr = '0; data_in = '0; mem_ack = 0; mem_rdata = '0;
    tick();
    tick();
    rst = 0;
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk16("rst_data_out", data_out, 16'h0000);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk_en = 1;
    // 1: lone ifetch
    rd_fix = 16'hA5A5; ireq = 1; iaddr = 16'h0010;
    wait_strobe("t1_wait", 20);
    chk1("t1_ir", instruction_ready, 1'b1);
    chk16("t1_dout", data_out, 16'hA5A5);
    chk16("t1_addr", cap_addr, 16'h0010);
    chk1("t1_wen", cap_wen, 1'b0);
    ireq = 0;
    tick();
    chk1("t1_pulse", instruction_ready, 1'b0);
    // 2: starvation limit
    rd_fix = 16'h5A5A; grants = ""; log_en = 1;
    iaddr = 16'h0040; daddr = 16'h0200; ireq = 1; read = 1;
    for (int k = 0; k < 4; k++) begin
      wait_strobe("t2_wait", 20);
      irl = instruction_ready ? {irl, "1"} : {irl, "0"};
    end
    ireq = 0; read = 0; log_en = 0;
    chk_s("t2_grants", grants, "DDDI");
    chk_s("t2_ir_seq", irl, "0001");
    chk16("t2_dout", data_out, 16'h5A5A);
    // 3: store leaves data_out alone
    rd_fix = 16'hFFFF; write = 1; daddr = 16'h0300; data_in = 16'h1234;
    wait_strobe("t3_wait", 20);
    chk1("t3_dr", data_ready, 1'b1);
    chk1("t3_wen", cap_wen, 1'b1);
    chk16("t3_wdata", cap_wdata, 16'h1234);
    chk16("t3_dout", data_out, 16'h5A5A);
    write = 0;
    // 4: flush during ifetch
    auto_ack = 0; mem_ack = 0; ireq = 1; iaddr = 16'h0050;
    wait_req("t4_req", 20);
    flush = 1; iaddr = 16'h0060;
    tick();
    flush = 0;
    tick();
    tick();
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 0;
    chk1("t4_no_ir", instruction_ready, 1'b0);
    chk1("t4_ready", ready, 1'b1);
    chk16("t4_dout", data_out, 16'hBEEF);
    rd_fix = 16'h1357; auto_ack = 1;
    wait_strobe("t4_wait", 20);
    chk1("t4_ir", instruction_ready, 1'b1);
    chk16("t4_addr", cap_addr, 16'h0060);
    chk16("t4_dout2", data_out, 16'h1357);
    ireq = 0;
    // 5: reset mid-access, late ack ignored
    auto_ack = 0; mem_ack = 0; read = 1; daddr = 16'h0400;
    wait_req("t5_req", 20);
    tick();
    rst = 1; read = 0;
    tick();
    rst = 0; mem_ack = 1; mem_rdata = 16'hDEAD;
    chk1("t5_req", mem_req, 1'b0);
    chk1("t5_wen", mem_wen, 1'b0);
    chk16("t5_addr", mem_addr, 16'h0000);
    chk16("t5_wdata", mem_wdata, 16'h0000);
    chk16("t5_dout", data_out, 16'h0000);
    chk1("t5_ready", ready, 1'b1);
    tick();
    mem_ack = 0;
    chk1("t5_no_dr", data_ready, 1'b0);
    chk1("t5_ready2", ready, 1'b1);
    chk16("t5_dout2", data_out, 16'h0000);
    // 6: long ack wait keeps operands stable
    write = 1; daddr = 16'h0500; data_in = 16'hCAFE;
    wait_req("t6_req", 20);
    stable = 1;
    for (int k = 0; k < 10; k++) begin
      data_in = 16'($urandom); daddr = 16'($urandom);
      tick();
      if (mem_req !== 1'b1 || mem_addr !== 16'h0500 || mem_wdata !== 16'hCAFE || ready !== 1'b0) stable = 0;
    end
    chk1("t6_stable", stable, 1'b1);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk1("t6_dr", data_ready, 1'b1);
    write = 0;
    auto_ack = 1;
    // Random traffic
    rand_rd = 1; rand_dly = 1;
    for (int c = 0; c < 3000; c++) begin
      if (instruction_ready) begin
        ireq = $urandom_range(0, 1) == 1; iaddr = 16'($urandom);
      end else if (!ireq && $urandom_range(0, 3) == 0) begin
        ireq = 1; iaddr = 16'($urandom);
      end
      if (data_ready) begin
        read = 0; write = 0;
      end else if (!read && !write && $urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(0, 2));
        read = r != 1; write = r != 0;
        daddr = 16'($urandom); data_in = 16'($urandom);
      end
      flush = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 199) == 0;
      tick();
    end
    rst = 0; ireq = 0; read = 0; write = 0; flush = 0;
    repeat (10) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
